// File: rtl/keypad_code_collector_pkg.sv
// Shared key-code constants, debounce state type and key classification helpers
// for the keypad code collector.
package keypad_code_collector_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic {
    WAIT_PRESS = 1'b0,
    HELD       = 1'b1
  } deb_state_e;

  // Scanner codes 0xC-0xE carry no meaning and are folded into "no key".
  function automatic logic [3:0] map_key(input logic [3:0] k);
    return (k >= 4'hC && k <= 4'hE) ? KEY_NONE : k;
  endfunction

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_code_collector_if.sv
// PIN hand-off channel: assembled code with a valid/ready handshake.
interface keypad_code_collector_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] code_out;
  logic                code_valid;
  logic                code_ready;

  modport master (output code_out, output code_valid, input code_ready);
  modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/keypad_code_collector_key_debouncer.sv
// Registers the raw scanner code and debounces it into a single key event per
// physical press; a release must be seen before any press is accepted.
module key_debouncer
  import keypad_code_collector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES);

  deb_state_e state_q, state_d;
  logic [3:0] sample_q, prev_q;
  logic [3:0] key_q, key_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       armed_q, armed_d;
  logic       same_key, same_none;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_PRESS;
      sample_q <= '0;
      prev_q   <= '0;
      key_q    <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= map_key(key_in);
      prev_q   <= sample_q;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    armed_d   = armed_q;
    cnt_d     = '0;
    key_event = 1'b0;
    cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    same_key  = (sample_q == prev_q) && (sample_q != KEY_NONE);
    same_none = (sample_q == prev_q) && (sample_q == KEY_NONE);

    unique case (state_q)
      WAIT_PRESS: begin
        // Until a clean release has been seen (e.g. after reset while a key is
        // still down), only release qualification runs.
        if (!armed_q) begin
          if (same_none) cnt_d = cnt_inc;
          if (cnt_d == DEB_MAX) begin
            armed_d = 1'b1;
            cnt_d   = '0;
          end
        end else begin
          if (same_key) cnt_d = cnt_inc;
          if (cnt_d == DEB_MAX) begin
            key_event = 1'b1;
            key_d     = sample_q;
            state_d   = HELD;
            cnt_d     = '0;
          end
        end
      end
      HELD: begin
        if (same_none) cnt_d = cnt_inc;
        if (cnt_d == DEB_MAX) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      default: state_d = WAIT_PRESS;
    endcase

    key_code = key_event ? sample_q : key_q;
  end

endmodule

// File: rtl/keypad_code_collector.sv
// Collects debounced keypad digits into a fixed-length PIN, hands it off over a
// valid/ready channel and flags short, overlong or timed-out entries.
module keypad_code_collector
  import keypad_code_collector_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     key_in,
  keypad_code_collector_if.master        code_if,
  output logic                           entry_err,
  output logic                           key_strobe,
  output logic [2:0]                     digit_count
);

  localparam int unsigned CODE_W  = 4 * DIGITS;
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]       DIG_MAX = 3'(DIGITS);

  logic              key_event;
  logic [3:0]        key_code;
  logic [CODE_W-1:0] buf_q, buf_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              strobe_q, strobe_d;
  logic [2:0]        count_q, count_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              clear;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_event(key_event),
    .key_code (key_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      strobe_q <= 1'b0;
      count_q  <= '0;
      tmo_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    buf_d    = buf_q;
    code_d   = code_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    strobe_d = key_event;
    count_d  = count_q;
    tmo_d    = tmo_q;
    clear    = 1'b0;

    if (valid_q && code_if.code_ready) valid_d = 1'b0;

    // A key event takes priority over a timeout expiring in the same cycle.
    if (key_event) begin
      tmo_d = '0;
      // While a PIN awaits hand-off the buffer is frozen; keys only strobe.
      if (!valid_q) begin
        if (is_digit(key_code)) begin
          if (count_q < DIG_MAX) begin
            buf_d   = (buf_q << 4) | CODE_W'(key_code);
            count_d = count_q + 3'd1;
          end else begin
            err_d = 1'b1;
            clear = 1'b1;
          end
        end else if (key_code == KEY_CLEAR) begin
          clear = 1'b1;
        end else if (key_code == KEY_ENTER) begin
          if (count_q == DIG_MAX) begin
            code_d  = buf_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          clear = 1'b1;
        end
      end
    end else if (count_q != 3'd0 && !valid_q && tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == TMO_MAX) begin
        err_d = 1'b1;
        clear = 1'b1;
      end
    end

    if (clear) begin
      buf_d   = '0;
      count_d = '0;
    end
  end

  assign code_if.code_out   = code_q;
  assign code_if.code_valid = valid_q;
  assign entry_err          = err_q;
  assign key_strobe         = strobe_q;
  assign digit_count        = count_q;

endmodule

// File: tb/tb_keypad_code_collector.sv
// Bench for keypad_code_collector: table-driven key sequences, directed corner
// cases and random keying, all checked cycle by cycle against a run-length model.
module tb_keypad_code_collector;
  import keypad_code_collector_pkg::*;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DEB    = 4;
  localparam int unsigned TMO    = 64;
  localparam int unsigned CW     = 4 * DIGITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'hF;
  logic       entry_err, key_strobe;
  logic [2:0] digit_count;

  keypad_code_collector_if #(.DIGITS(DIGITS)) code_if ();

  keypad_code_collector #(
    .DIGITS         (DIGITS),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .code_if    (code_if),
    .entry_err  (entry_err),
    .key_strobe (key_strobe),
    .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state (values visible after each clock edge).
  int          m_digits[$];
  logic [CW-1:0] m_code;
  bit          m_valid, m_err, m_strobe;
  int          m_last_ev;
  int          run_val, run_len;
  bit          released, ev_now;
  logic [3:0]  ev_code;

  int obs_strobes = 0, obs_errs = 0, obs_valids = 0;
  int last_strobe_cyc = -1, last_err_cyc = -1;
  logic [CW-1:0] obs_code = '0;

  typedef struct {
    logic [23:0]  keys;   // first key in the least significant nibble
    int           nkeys;
    int           strobes;
    int           errs;
    int           valids;
    logic [CW-1:0] code;
    int           count_end;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_digits.delete();
    m_code    = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
    m_strobe  = 1'b0;
    m_last_ev = 0;
    run_val   = 16;  // matches no real code: next sample starts a fresh run
    run_len   = 0;
    released  = 1'b0;
    ev_now    = 1'b0;
    ev_code   = '0;
  endtask

  task automatic apply_key(input logic [3:0] c);
    logic [CW-1:0] acc;
    if (c <= 4'd9) begin
      if (m_digits.size() < DIGITS) m_digits.push_back(int'(c));
      else begin
        m_err = 1'b1;
        m_digits.delete();
      end
    end else if (c == 4'hA) begin
      m_digits.delete();
    end else if (c == 4'hB) begin
      if (m_digits.size() == DIGITS) begin
        acc = '0;
        foreach (m_digits[i]) acc = acc * 16 + CW'(m_digits[i]);
        m_code  = acc;
        m_valid = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_digits.delete();
    end
  endtask

  // Advance the model across one clock edge given this cycle's inputs.
  task automatic model_step(input logic [3:0] k, input logic r);
    int         n1;
    bit         old_valid, ev_next;
    logic [3:0] mk, code_next;
    n1        = cyc + 1;
    old_valid = m_valid;
    m_strobe  = ev_now;
    m_err     = 1'b0;
    code_next = '0;
    if (old_valid && r) m_valid = 1'b0;
    if (ev_now) begin
      m_last_ev = n1;
      if (!old_valid) apply_key(ev_code);
    end else if (m_digits.size() != 0 && n1 - m_last_ev == int'(TMO)) begin
      m_err = 1'b1;
      m_digits.delete();
    end
    // Press/release qualify once a run of DEB+1 identical codes is complete.
    mk = (k >= 4'hC && k <= 4'hE) ? 4'hF : k;
    if (int'(mk) == run_val) run_len++;
    else begin
      run_val = int'(mk);
      run_len = 1;
    end
    ev_next = 1'b0;
    if (run_len == int'(DEB) + 1) begin
      if (mk == 4'hF) released = 1'b1;
      else if (released) begin
        ev_next   = 1'b1;
        code_next = mk;
        released  = 1'b0;
      end
    end
    ev_now  = ev_next;
    ev_code = code_next;
  endtask

  task automatic tick(input logic [3:0] k, input logic r);
    key_in = k;
    code_if.code_ready = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    cyc++;
    chk("key_strobe", 32'(key_strobe), 32'(m_strobe));
    chk("entry_err", 32'(entry_err), 32'(m_err));
    chk("code_valid", 32'(code_if.code_valid), 32'(m_valid));
    chk("digit_count", 32'(digit_count), 32'(m_digits.size()));
    chk("code_out", 32'(code_if.code_out), 32'(m_code));
    if (key_strobe) begin
      obs_strobes++;
      last_strobe_cyc = cyc;
    end
    if (entry_err) begin
      obs_errs++;
      last_err_cyc = cyc;
    end
    if (code_if.code_valid) begin
      obs_valids++;
      obs_code = code_if.code_out;
    end
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int rel, input logic r);
    repeat (hold) tick(k, r);
    repeat (rel) tick(4'hF, r);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'hF, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " key_strobe"}, 32'(key_strobe), 32'd0);
    chk({tag, " entry_err"}, 32'(entry_err), 32'd0);
    chk({tag, " code_valid"}, 32'(code_if.code_valid), 32'd0);
    chk({tag, " digit_count"}, 32'(digit_count), 32'd0);
    chk({tag, " code_out"}, 32'(code_if.code_out), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    int          s0, e0, v0;
    logic [23:0] kv;
    logic [3:0]  rk;

    vecs[0] = '{24'h0B4321, 5, 5, 0, 1, 16'h1234, 0};
    vecs[1] = '{24'h000B99, 3, 3, 1, 0, 16'h0000, 0};
    vecs[2] = '{24'h054321, 5, 5, 1, 0, 16'h0000, 0};
    vecs[3] = '{24'h000A21, 3, 3, 0, 0, 16'h0000, 0};
    vecs[4] = '{24'h00000B, 1, 1, 1, 0, 16'h0000, 0};
    vecs[5] = '{24'h000065, 2, 2, 0, 0, 16'h0000, 2};
    vecs[6] = '{24'h0B5678, 5, 5, 0, 1, 16'h8765, 0};
    vecs[7] = '{24'h0000BA, 2, 2, 1, 0, 16'h0000, 0};
    vecs[8] = '{24'h0B7000, 5, 5, 0, 1, 16'h0007, 0};
    vecs[9] = '{24'hBA4321, 6, 6, 1, 0, 16'h0000, 0};

    code_if.code_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle(10);

    // Table-driven entries, each key held 10 and released 10 cycles.
    for (int v = 0; v < 10; v++) begin
      s0 = obs_strobes;
      e0 = obs_errs;
      v0 = obs_valids;
      kv = vecs[v].keys;
      for (int i = 0; i < vecs[v].nkeys; i++) press(kv[4*i +: 4], 10, 10, 1'b1);
      chk($sformatf("vec%0d strobes", v), 32'(obs_strobes - s0), 32'(vecs[v].strobes));
      chk($sformatf("vec%0d errs", v), 32'(obs_errs - e0), 32'(vecs[v].errs));
      chk($sformatf("vec%0d valid cycles", v), 32'(obs_valids - v0), 32'(vecs[v].valids));
      if (vecs[v].valids > 0) chk($sformatf("vec%0d code", v), 32'(obs_code), 32'(vecs[v].code));
      chk($sformatf("vec%0d count", v), 32'(digit_count), 32'(vecs[v].count_end));
      idle(80);
    end

    // Hand-off stalled: buffer frozen while a later key still strobes.
    s0 = obs_strobes;
    press(4'h1, 10, 10, 1'b0);
    press(4'h2, 10, 10, 1'b0);
    press(4'h3, 10, 10, 1'b0);
    press(4'h4, 10, 10, 1'b0);
    press(4'hB, 10, 10, 1'b0);
    repeat (20) tick(4'hF, 1'b0);
    press(4'h7, 10, 10, 1'b0);
    chk("stall strobes", 32'(obs_strobes - s0), 32'd6);
    chk("stall code_out", 32'(code_if.code_out), 32'h1234);
    chk("stall code_valid", 32'(code_if.code_valid), 32'd1);
    chk("stall count", 32'(digit_count), 32'd0);
    tick(4'hF, 1'b1);
    chk("handshake valid drop", 32'(code_if.code_valid), 32'd0);
    chk("handshake count", 32'(digit_count), 32'd0);
    idle(10);

    // Bouncing contact then a stable press gives a single event.
    s0 = obs_strobes;
    for (int i = 0; i < 20; i++) tick(((i / 2) % 2 == 0) ? 4'h5 : 4'hF, 1'b1);
    press(4'h5, 10, 10, 1'b1);
    chk("bounce strobes", 32'(obs_strobes - s0), 32'd1);
    chk("bounce count", 32'(digit_count), 32'd1);
    press(4'hA, 10, 10, 1'b1);

    // Inactivity timeout on a partial entry.
    e0 = obs_errs;
    press(4'h3, 10, 10, 1'b1);
    s0 = last_strobe_cyc;
    idle(70);
    chk("timeout errs", 32'(obs_errs - e0), 32'd1);
    chk("timeout delay", 32'(last_err_cyc - s0), 32'(TMO));
    chk("timeout count", 32'(digit_count), 32'd0);

    // Reset while a key is held: that key must not be re-accepted.
    press(4'h1, 10, 10, 1'b1);
    press(4'h2, 10, 10, 1'b1);
    repeat (8) tick(4'h3, 1'b1);
    pulse_reset();
    s0 = obs_strobes;
    repeat (20) tick(4'h3, 1'b1);
    chk("held after reset strobes", 32'(obs_strobes - s0), 32'd0);
    chk("held after reset count", 32'(digit_count), 32'd0);
    idle(10);
    press(4'h4, 10, 10, 1'b1);
    chk("re-press strobes", 32'(obs_strobes - s0), 32'd1);
    chk("re-press count", 32'(digit_count), 32'd1);
    idle(80);

    // Random keying, hold lengths and ready, checked by the model every cycle.
    for (int n = 0; n < 300; n++) begin
      rk = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) tick(rk, 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(1, 12)) tick(4'hF, 1'($urandom_range(0, 3) != 0));
      if (n % 50 == 49) repeat (70) tick(4'hF, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
